uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter, the transmit counterpart of the computer core's ser_rx receiver. It drives ftdi_rxd so the Galaksija core can send serial output back to the host over FTDI USB. Bytes are written through a valid/ready handshake into an internal FIFO, then serialized LSB-first at a fixed baud rate derived from the system clock.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the buffered UART transmitter.
// Also intended for a later buffered receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int f_baud_div(input int clk_freq,
                                    input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic bit f_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy.
// Push when full and pop when empty are ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int C_width = 8,
  parameter int C_depth = 16,
  localparam int C_aw   = f_clog2(C_depth)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [C_width-1:0] i_data,
  input  logic               i_pop,
  output logic [C_width-1:0] o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [C_aw:0]      o_level
);

  logic [C_width-1:0] r_mem [C_depth];
  logic [C_aw-1:0]    r_wr_ptr;
  logic [C_aw-1:0]    r_rd_ptr;
  logic [C_aw:0]      r_level;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_level == (C_aw+1)'(C_depth));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: handshake into a FIFO, LSB-first
// serializer with a fixed integer baud divisor and back-to-back frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int C_clk_freq   = 25000000,
  parameter int C_baud       = 115200,
  parameter int C_fifo_depth = 16,
  parameter int C_stop_bits  = 1,
  localparam int C_lw        = f_clog2(C_fifo_depth) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            ser_tx,
  output logic            busy,
  output logic [C_lw-1:0] fifo_level
);

  localparam int C_div = f_baud_div(C_clk_freq, C_baud);
  localparam int C_cw  = f_clog2(C_div);

  if (C_div < 2) begin : g_bad_div
    $error("uart_tx_fifo: baud divisor must be at least 2");
  end
  if (!f_is_pow2(C_fifo_depth) || C_fifo_depth < 2) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO depth must be a power of two >= 2");
  end
  if (C_stop_bits != 1 && C_stop_bits != 2) begin : g_bad_stop
    $error("uart_tx_fifo: stop bits must be 1 or 2");
  end

  tx_state_e       r_state;
  logic [C_cw-1:0] r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic            r_stop_cnt;
  logic [7:0]      r_shift;
  logic            r_ser_tx;

  logic [7:0]      w_fifo_data;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_baud_end;
  logic            w_stop_last;

  assign w_push      = tx_valid && !w_full;
  assign w_baud_end  = (r_baud_cnt == C_cw'(C_div - 1));
  assign w_stop_last = (r_stop_cnt == 1'(C_stop_bits - 1));

  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_STOP:  w_pop = w_baud_end && w_stop_last && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .C_width (8),
    .C_depth (C_fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_ser_tx   <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ser_tx   <= 1'b1;
          r_baud_cnt <= '0;
          if (!w_empty) begin
            r_shift   <= w_fifo_data;
            r_bit_cnt <= '0;
            r_ser_tx  <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_ser_tx   <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_ser_tx   <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_ser_tx  <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (w_stop_last) begin
              // Queued byte starts its start bit with no idle gap.
              if (!w_empty) begin
                r_shift   <= w_fifo_data;
                r_bit_cnt <= '0;
                r_ser_tx  <= 1'b0;
                r_state   <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_tx   = r_ser_tx;
  assign tx_ready = !w_full;
  assign busy     = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with one and two stop bits,
// compared every cycle against a frame-timeline reference model.
module tb_uart_tx_fifo;

  localparam int DIV    = 10;
  localparam int DEPTH  = 16;
  localparam int FRAME0 = 10 * DIV;
  localparam int FRAME1 = 11 * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic       rdy0, tx0, busy0;
  logic       rdy1, tx1, busy1;
  logic [4:0] lvl0, lvl1;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .C_clk_freq   (1000000),
    .C_baud       (100000),
    .C_fifo_depth (DEPTH),
    .C_stop_bits  (1)
  ) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (rdy0),
    .ser_tx     (tx0),
    .busy       (busy0),
    .fifo_level (lvl0)
  );

  uart_tx_fifo #(
    .C_clk_freq   (1000000),
    .C_baud       (100000),
    .C_fifo_depth (DEPTH),
    .C_stop_bits  (2)
  ) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (rdy1),
    .ser_tx     (tx1),
    .busy       (busy1),
    .fifo_level (lvl1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got,
                          input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: a list of accepted bytes plus, per DUT, the frame on the
  // line and how many cycles into it we are.
  logic [7:0] m_buf [2][4096];
  int         m_head [2];
  int         m_tail [2];
  bit         m_act [2];
  int         m_off [2];
  logic [7:0] m_byte [2];

  function automatic int frame_len(input int i);
    return (i == 0) ? FRAME0 : FRAME1;
  endfunction

  function automatic int m_level(input int i);
    return m_tail[i] - m_head[i];
  endfunction

  function automatic int exp_tx(input int i);
    int b;
    if (!m_act[i]) return 1;
    b = m_off[i] / DIV;
    if (b == 0) return 0;
    if (b <= 8) return int'(m_byte[i][b-1]);
    return 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_head[i] = 0;
      m_tail[i] = 0;
      m_act[i]  = 1'b0;
      m_off[i]  = 0;
      m_byte[i] = 8'h00;
    end
  endtask

  task automatic model_step(input int i, input bit v,
                            input logic [7:0] d);
    int  pre;
    bit  acc;
    bit  take;
    pre  = m_level(i);
    acc  = v && (pre < DEPTH);
    take = 1'b0;
    if (m_act[i]) begin
      if (m_off[i] == frame_len(i) - 1) begin
        if (pre > 0) take = 1'b1;
        else m_act[i] = 1'b0;
      end else begin
        m_off[i]++;
      end
    end else if (pre > 0) begin
      take = 1'b1;
    end
    if (take) begin
      m_byte[i] = m_buf[i][m_head[i]];
      m_head[i]++;
      m_act[i] = 1'b1;
      m_off[i] = 0;
    end
    if (acc) begin
      m_buf[i][m_tail[i]] = d;
      m_tail[i]++;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        model_step(0, tx_valid, tx_data);
        model_step(1, tx_valid, tx_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_eq("ser_tx0", int'(tx0), exp_tx(0));
      check_eq("ser_tx1", int'(tx1), exp_tx(1));
      check_eq("level0", int'(lvl0), m_level(0));
      check_eq("level1", int'(lvl1), m_level(1));
      check_eq("ready0", int'(rdy0), int'(m_level(0) < DEPTH));
      check_eq("ready1", int'(rdy1), int'(m_level(1) < DEPTH));
      check_eq("busy0", int'(busy0), int'(m_act[0] || m_level(0) != 0));
      check_eq("busy1", int'(busy1), int'(m_act[1] || m_level(1) != 0));
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while ((m_act[0] || m_act[1] || m_level(0) != 0 ||
            m_level(1) != 0) && g < 6000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 6000) check_eq("drain_timeout", 1, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [9:0] a5_line;
  bit         saw_stall;
  int         base;
  int         g;

  initial begin
    a5_line = 10'b1101001010;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", int'(tx0), 1);
    check_eq("rst_ready", int'(rdy0), 1);
    check_eq("rst_busy", int'(busy0), 0);
    check_eq("rst_level", int'(lvl0), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte from idle, sampled mid-bit.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 6 : 10) @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("a5_bit%0d", k), int'(tx0), int'(a5_line[k]));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("a5_busy_end-1", int'(busy0), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("a5_busy_end", int'(busy0), 0);
    wait_idle();

    // Three-byte burst on consecutive cycles.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    @(posedge clk);
    #1 tx_data = 8'h55;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    check_eq("burst_peak", int'(lvl0), 2);
    wait_idle();

    // Hold valid until 20 bytes are taken; the FIFO must fill and stall.
    saw_stall = 1'b0;
    base      = m_tail[0];
    tx_valid  = 1'b1;
    tx_data   = 8'($urandom);
    g         = 0;
    while (m_tail[0] - base < 20 && g < 1000) begin
      @(posedge clk);
      #1 tx_data = 8'($urandom);
      if (!rdy0) saw_stall = 1'b1;
      g++;
    end
    tx_valid = 1'b0;
    check_eq("fill_accepted", m_tail[0] - base, 20);
    check_eq("fill_stall", int'(saw_stall), 1);
    wait_idle();

    // Reset at cycle 35 of a frame while the line is low.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (36) @(posedge clk);
    #3;
    check_eq("pre_reset_low", int'(tx0), 0);
    reset_n = 1'b0;
    #1;
    check_eq("async_tx0", int'(tx0), 1);
    check_eq("async_tx1", int'(tx1), 1);
    check_eq("async_level", int'(lvl0), 0);
    check_eq("async_busy", int'(busy0), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check_eq("post_reset_busy", int'(busy0), 0);
    check_eq("post_reset_tx", int'(tx0), 1);

    // Second byte pushed during the stop bit follows with no gap.
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (94) @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("stop_hold", int'(tx0), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_start", int'(tx0), 0);
    wait_idle();

    // Two stop bits: the frame lasts 110 cycles.
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (110) @(posedge clk);
    @(negedge clk);
    check_eq("stop2_busy_end-1", int'(busy1), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("stop2_busy_end", int'(busy1), 0);
    wait_idle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
